// File: rtl/neuron_reg_pkg.sv
// Shared types and defaults for the digit recogniser register bank.
// Holds the scan FSM state type and the saturating add used by accumulating writes.
package neuron_reg_pkg;

  localparam int NEURON_DATA_W = 4;
  localparam int NEURON_COUNT  = 8;
  localparam int DIGIT_COUNT   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Unsigned a+b clamped to the largest value representable in width bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum_v;
    logic [32:0] max_v;
    sum_v = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << width) - 33'd1;
    if (sum_v > max_v) begin
      return max_v[31:0];
    end else begin
      return sum_v[31:0];
    end
  endfunction

endpackage

// File: rtl/neuron_reg_bank_cell.sv
// One storage register of the bank with its own address decode.
// NEURON_REG_ACCUM_EN adds accum_en, turning a write into a saturating accumulate.
module neuron_reg_bank_cell
  import neuron_reg_pkg::*;
#(
  parameter int ADDRESS = 0,
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
`ifdef NEURON_REG_ACCUM_EN
  input  logic              accum_en,
`endif
  output logic [DATA_W-1:0] value
);

  logic              hit_s;
  logic [DATA_W-1:0] next_s;
  logic [DATA_W-1:0] value_r;

  assign hit_s = write_en && (address == ADDR_W'(ADDRESS));

  // Select the value a write would store: overwrite or saturating accumulate.
  always_comb begin
    next_s = data_in;
`ifdef NEURON_REG_ACCUM_EN
    if (accum_en) begin
      next_s = DATA_W'(sat_add(32'(value_r), 32'(data_in), DATA_W));
    end else begin
      next_s = data_in;
    end
`endif
  end

  // Storage register, updated only when this cell is addressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= '0;
    end else if (hit_s) begin
      value_r <= next_s;
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/neuron_reg_bank.sv
// Neuron activation / digit weight register bank with registered read port and argmax scanner.
// Optional NEURON_REG_ACCUM_EN adds the accum_en port for saturating accumulate writes.
module neuron_reg_bank
  import neuron_reg_pkg::*;
#(
  parameter int DATA_W   = NEURON_DATA_W,
  parameter int N_NEURON = NEURON_COUNT,
  parameter int N_DIGIT  = DIGIT_COUNT,
  parameter int ADDR_W   = 5,
  localparam int IDX_W   = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_en,
  input  logic [ADDR_W-1:0]         address,
  input  logic [DATA_W-1:0]         data_in,
`ifdef NEURON_REG_ACCUM_EN
  input  logic                      accum_en,
`endif
  input  logic                      read_en,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_valid,
  output logic [N_DIGIT*DATA_W-1:0] digit_weights,
  input  logic                      scan_start,
  output logic                      scan_busy,
  output logic                      scan_done,
  output logic [IDX_W-1:0]          best_digit,
  output logic [DATA_W-1:0]         best_weight
);

  localparam int N_TOTAL = N_NEURON + N_DIGIT;

  if ((64'd1 << ADDR_W) < 64'(N_TOTAL)) begin : g_addr_w_check
    $error("neuron_reg_bank: ADDR_W too small for N_NEURON+N_DIGIT registers");
  end

  logic [DATA_W-1:0] reg_val_s [N_TOTAL];
  logic [DATA_W-1:0] weights_s [N_DIGIT];

  for (genvar g = 0; g < N_TOTAL; g++) begin : g_cell
    neuron_reg_bank_cell #(
      .ADDRESS (g),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .write_en (write_en),
      .address  (address),
      .data_in  (data_in),
`ifdef NEURON_REG_ACCUM_EN
      .accum_en (accum_en),
`endif
      .value    (reg_val_s[g])
    );
  end

  for (genvar d = 0; d < N_DIGIT; d++) begin : g_weight
    assign weights_s[d]                          = reg_val_s[N_NEURON + d];
    assign digit_weights[d*DATA_W +: DATA_W]     = reg_val_s[N_NEURON + d];
  end

  // ---------------- read port ----------------
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;

  // Address mux; anything beyond the last register reads as all ones.
  always_comb begin
    rd_data_s = {DATA_W{1'b1}};
    for (int i = 0; i < N_TOTAL; i++) begin
      rd_data_s = (address == ADDR_W'(i)) ? reg_val_s[i] : rd_data_s;
    end
  end

  // Registered read: samples pre-write storage, so same-cycle writes are not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
    end else begin
      data_valid_r <= read_en;
      data_out_r   <= read_en ? rd_data_s : data_out_r;
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;

  // ---------------- argmax scanner ----------------
  scan_state_t       state_r, state_next_s;
  logic [IDX_W-1:0]  idx_r, idx_next_s;
  logic [IDX_W-1:0]  best_digit_r, best_digit_next_s;
  logic [DATA_W-1:0] best_weight_r, best_weight_next_s;
  logic [DATA_W-1:0] weight_sel_s;
  logic              scan_busy_r, scan_done_r;

  // Weight currently under comparison.
  always_comb begin
    weight_sel_s = '0;
    for (int i = 0; i < N_DIGIT; i++) begin
      weight_sel_s = (idx_r == IDX_W'(i)) ? weights_s[i] : weight_sel_s;
    end
  end

  // Scan next-state logic; strict greater-than keeps the lowest index on ties.
  always_comb begin
    state_next_s       = state_r;
    idx_next_s         = idx_r;
    best_digit_next_s  = best_digit_r;
    best_weight_next_s = best_weight_r;
    case (state_r)
      IDLE: begin
        if (scan_start) begin
          best_weight_next_s = weights_s[0];
          best_digit_next_s  = '0;
          idx_next_s         = IDX_W'(1);
          state_next_s       = (N_DIGIT == 1) ? DONE : SCAN;
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN: begin
        if (weight_sel_s > best_weight_r) begin
          best_weight_next_s = weight_sel_s;
          best_digit_next_s  = idx_r;
        end else begin
          best_weight_next_s = best_weight_r;
          best_digit_next_s  = best_digit_r;
        end
        if (idx_r == IDX_W'(N_DIGIT - 1)) begin
          state_next_s = DONE;
        end else begin
          idx_next_s = idx_r + IDX_W'(1);
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Scan state, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      idx_r         <= '0;
      best_digit_r  <= '0;
      best_weight_r <= '0;
      scan_busy_r   <= 1'b0;
      scan_done_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      idx_r         <= idx_next_s;
      best_digit_r  <= best_digit_next_s;
      best_weight_r <= best_weight_next_s;
      scan_busy_r   <= (state_next_s == SCAN);
      scan_done_r   <= (state_next_s == DONE);
    end
  end

  assign scan_busy   = scan_busy_r;
  assign scan_done   = scan_done_r;
  assign best_digit  = best_digit_r;
  assign best_weight = best_weight_r;

endmodule

// File: tb/tb_neuron_reg_bank.sv
// Directed self-checking bench for neuron_reg_bank at default parameters.
// Define NEURON_REG_ACCUM_EN to also exercise the saturating accumulate path.
module tb_neuron_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write_en = 1'b0;
  logic [4:0]  address = 5'd0;
  logic [3:0]  data_in = 4'd0;
`ifdef NEURON_REG_ACCUM_EN
  logic        accum_en = 1'b0;
`endif
  logic        read_en = 1'b0;
  logic [3:0]  data_out;
  logic        data_valid;
  logic [39:0] digit_weights;
  logic        scan_start = 1'b0;
  logic        scan_busy;
  logic        scan_done;
  logic [3:0]  best_digit;
  logic [3:0]  best_weight;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0]  model [18];
  logic [39:0] exp_w;

  neuron_reg_bank dut (
    .clk           (clk),
    .rst           (rst),
    .write_en      (write_en),
    .address       (address),
    .data_in       (data_in),
`ifdef NEURON_REG_ACCUM_EN
    .accum_en      (accum_en),
`endif
    .read_en       (read_en),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .digit_weights (digit_weights),
    .scan_start    (scan_start),
    .scan_busy     (scan_busy),
    .scan_done     (scan_done),
    .best_digit    (best_digit),
    .best_weight   (best_weight)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [3:0] d);
    write_en = 1'b1;
    address  = a;
    data_in  = d;
    tick();
    write_en = 1'b0;
    if (a < 5'd18) model[a] = d;
  endtask

  task automatic do_read(input logic [4:0] a);
    read_en = 1'b1;
    address = a;
    tick();
    read_en = 1'b0;
  endtask

  task automatic build_exp_w;
    for (int d = 0; d < 10; d++) exp_w[d*4 +: 4] = model[8 + d];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 18; i++) model[i] = 4'h0;
    vectors++;
    if ({data_out, data_valid, scan_busy, scan_done, best_digit, best_weight} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {data_out, data_valid, scan_busy, scan_done, best_digit, best_weight});
    end
    vectors++;
    if (digit_weights !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_weights: got %h expected 0", digit_weights);
    end
    for (int i = 0; i < 18; i++) begin
      do_read(5'(i));
      vectors++;
      if (data_valid !== 1'b1 || data_out !== 4'h0) begin
        miscompares++;
        $display("FAIL reset_read[%0d]: got valid=%b data=%h expected valid=1 data=0", i, data_valid, data_out);
      end
    end
  endtask

  task automatic test_write_read;
    do_write(5'd3, 4'hA);
    do_read(5'd3);
    vectors++;
    if (data_valid !== 1'b1 || data_out !== 4'hA) begin
      miscompares++;
      $display("FAIL write_read: got valid=%b data=%h expected valid=1 data=a", data_valid, data_out);
    end
    tick();
    vectors++;
    if (data_valid !== 1'b0 || data_out !== 4'hA) begin
      miscompares++;
      $display("FAIL read_idle_hold: got valid=%b data=%h expected valid=0 data=a", data_valid, data_out);
    end
  endtask

  task automatic test_out_of_range;
    do_write(5'd20, 4'h5);
    build_exp_w();
    vectors++;
    if (digit_weights !== exp_w) begin
      miscompares++;
      $display("FAIL oor_write_weights: got %h expected %h", digit_weights, exp_w);
    end
    do_read(5'd20);
    vectors++;
    if (data_valid !== 1'b1 || data_out !== 4'hF) begin
      miscompares++;
      $display("FAIL oor_read: got valid=%b data=%h expected valid=1 data=f", data_valid, data_out);
    end
    for (int i = 0; i < 8; i++) begin
      do_read(5'(i));
      vectors++;
      if (data_out !== model[i]) begin
        miscompares++;
        $display("FAIL oor_neuron[%0d]: got %h expected %h", i, data_out, model[i]);
      end
    end
  endtask

  task automatic test_read_before_write;
    do_write(5'd2, 4'h3);
    write_en = 1'b1;
    read_en  = 1'b1;
    address  = 5'd2;
    data_in  = 4'h7;
    tick();
    write_en = 1'b0;
    read_en  = 1'b0;
    model[2] = 4'h7;
    vectors++;
    if (data_valid !== 1'b1 || data_out !== 4'h3) begin
      miscompares++;
      $display("FAIL rbw_old: got valid=%b data=%h expected valid=1 data=3", data_valid, data_out);
    end
    do_read(5'd2);
    vectors++;
    if (data_out !== 4'h7) begin
      miscompares++;
      $display("FAIL rbw_new: got %h expected 7", data_out);
    end
  endtask

  task automatic test_scan;
    logic [3:0] w [10];
    int j;
    int busy_cnt;
    w = '{4'd2, 4'd9, 4'd4, 4'd9, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8};
    for (int d = 0; d < 10; d++) do_write(5'(8 + d), w[d]);
    build_exp_w();
    vectors++;
    if (digit_weights !== exp_w) begin
      miscompares++;
      $display("FAIL scan_weights_view: got %h expected %h", digit_weights, exp_w);
    end
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    j = 0;
    busy_cnt = 0;
    while (scan_done !== 1'b1 && j < 20) begin
      if (scan_busy === 1'b1) busy_cnt++;
      tick();
      j++;
    end
    vectors++;
    if (j != 9) begin
      miscompares++;
      $display("FAIL scan_latency: got %0d cycles expected 9", j);
    end
    vectors++;
    if (busy_cnt != 9) begin
      miscompares++;
      $display("FAIL scan_busy_len: got %0d expected 9", busy_cnt);
    end
    vectors++;
    if (best_digit !== 4'd1 || best_weight !== 4'd9) begin
      miscompares++;
      $display("FAIL scan_result: got digit=%0d weight=%h expected digit=1 weight=9", best_digit, best_weight);
    end
    tick();
    vectors++;
    if (scan_done !== 1'b0 || scan_busy !== 1'b0 || best_digit !== 4'd1 || best_weight !== 4'd9) begin
      miscompares++;
      $display("FAIL scan_after_done: got done=%b busy=%b digit=%0d weight=%h expected 0 0 1 9",
               scan_done, scan_busy, best_digit, best_weight);
    end
  endtask

  task automatic test_scan_reset;
    int j;
    int done_seen;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (scan_done === 1'b1) done_seen++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 18; i++) model[i] = 4'h0;
    if (scan_done === 1'b1) done_seen++;
    vectors++;
    if ({data_out, data_valid, scan_busy, scan_done, best_digit, best_weight} !== 15'd0 || digit_weights !== 40'd0) begin
      miscompares++;
      $display("FAIL scan_reset_outputs: got %h / %h expected 0",
               {data_out, data_valid, scan_busy, scan_done, best_digit, best_weight}, digit_weights);
    end
    // Fresh scan right after reset; a weight written mid-scan must be seen.
    scan_start = 1'b1;
    tick();
    vectors++;
    if (scan_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL scan_restart: got busy=%b expected 1", scan_busy);
    end
    write_en = 1'b1;
    address  = 5'd13;
    data_in  = 4'h6;
    tick();
    write_en = 1'b0;
    model[13] = 4'h6;
    j = 1;
    while (scan_done !== 1'b1 && j < 20) begin
      tick();
      j++;
    end
    scan_start = 1'b0;
    vectors++;
    if (done_seen != 0 || j != 9) begin
      miscompares++;
      $display("FAIL scan_abort_timing: got early_done=%0d latency=%0d expected 0 and 9", done_seen, j);
    end
    vectors++;
    if (best_digit !== 4'd5 || best_weight !== 4'h6) begin
      miscompares++;
      $display("FAIL scan_midwrite: got digit=%0d weight=%h expected digit=5 weight=6", best_digit, best_weight);
    end
    tick();
    vectors++;
    if (scan_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL scan_start_ignored: got busy=%b expected 0", scan_busy);
    end
  endtask

`ifdef NEURON_REG_ACCUM_EN
  task automatic test_accum;
    do_write(5'd0, 4'hC);
    accum_en = 1'b1;
    do_write(5'd0, 4'h6);
    accum_en = 1'b0;
    do_read(5'd0);
    vectors++;
    if (data_out !== 4'hF) begin
      miscompares++;
      $display("FAIL accum_sat: got %h expected f", data_out);
    end
    do_write(5'd1, 4'h2);
    accum_en = 1'b1;
    do_write(5'd1, 4'h1);
    accum_en = 1'b0;
    do_read(5'd1);
    vectors++;
    if (data_out !== 4'h3) begin
      miscompares++;
      $display("FAIL accum_add: got %h expected 3", data_out);
    end
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_write_read();
    test_out_of_range();
    test_read_before_write();
    test_scan();
    test_scan_reset();
`ifdef NEURON_REG_ACCUM_EN
    test_accum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
